// File: rtl/divider_fixed_if.sv
// divider_fixed_if: operand/request and result/status bundle for the fixed-point divider
//   master drives operands and start; slave returns the quotient and status.
interface divider_fixed_if;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        start;
    logic [15:0] result;
    logic        overflow_flag;
    logic        div_by_zero;
    logic        busy;
    logic        finish;

    modport master (
        output dividend, divisor, start,
        input  result, overflow_flag, div_by_zero, busy, finish
    );

    modport slave (
        input  dividend, divisor, start,
        output result, overflow_flag, div_by_zero, busy, finish
    );
endinterface

// File: rtl/divider_fixed.sv
// divider_fixed: sequential signed Q8.7 divider, non-restoring, one quotient bit per clock
//   with round-half-away-from-zero, sign restore and saturation; fixed 27-cycle latency.
module divider_fixed #(
    parameter int FRAC_BITS = 7
) (
    input logic            clk,
    input logic            rst,
    divider_fixed_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, ITER, FINAL, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [24:0] n_q, n_d, q_q, q_d;
    logic [16:0] bm_q, bm_d;
    logic [17:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sign_q, sign_d;
    logic [15:0] result_q, result_d;
    logic        ovf_q, ovf_d, dbz_q, dbz_d, busy_q, busy_d, finish_q, finish_d;

    logic [16:0] a_mag, b_mag;
    logic [17:0] rem_sh, rem_nx;
    logic [24:0] qr, qr_neg;
    logic        bz, sat;

    always_comb begin
        a_mag  = a_q[15] ? 17'd0 - {1'b1, a_q} : {1'b0, a_q};
        b_mag  = b_q[15] ? 17'd0 - {1'b1, b_q} : {1'b0, b_q};
        // Non-restoring step: a negative remainder adds the divisor back instead of subtracting
        rem_sh = {rem_q[16:0], n_q[24]};
        rem_nx = rem_q[17] ? rem_sh + {1'b0, bm_q} : rem_sh - {1'b0, bm_q};
        qr     = {1'b0, q_q[24:1]} + 25'(q_q[0]);
        qr_neg = 25'd0 - qr;
        bz     = bm_q == 17'd0;
        sat    = sign_q ? qr > 25'd32768 : qr > 25'd32767;
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        q_d      = q_q;
        bm_d     = bm_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        busy_d   = busy_q;
        finish_d = finish_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d      = bus.dividend;
                    b_d      = bus.divisor;
                    busy_d   = 1'b1;
                    finish_d = 1'b0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                n_d     = 25'(a_mag) << (FRAC_BITS + 1);
                bm_d    = b_mag;
                sign_d  = a_q[15] ^ b_q[15];
                rem_d   = 18'd0;
                q_d     = 25'd0;
                cnt_d   = 5'd0;
                ovf_d   = 1'b0;
                dbz_d   = 1'b0;
                state_d = ITER;
            end
            ITER: begin
                rem_d   = rem_nx;
                q_d     = {q_q[23:0], ~rem_nx[17]};
                n_d     = {n_q[23:0], 1'b0};
                cnt_d   = cnt_q + 5'd1;
                state_d = cnt_q == 5'd24 ? FINAL : ITER;
            end
            FINAL: begin
                dbz_d    = bz;
                ovf_d    = bz | sat;
                result_d = bz     ? (a_q[15] ? 16'h8000 : 16'h7FFF) :
                           sign_q ? (sat ? 16'h8000 : qr_neg[15:0]) :
                                    (sat ? 16'h7FFF : qr[15:0]);
                busy_d   = 1'b0;
                finish_d = 1'b1;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            q_q      <= '0;
            bm_q     <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            q_q      <= q_d;
            bm_q     <= bm_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
        end
    end

    assign bus.result        = result_q;
    assign bus.overflow_flag = ovf_q;
    assign bus.div_by_zero   = dbz_q;
    assign bus.busy          = busy_q;
    assign bus.finish        = finish_q;
endmodule

// File: tb/tb_divider_fixed.sv
// tb_divider_fixed: scoreboard bench for divider_fixed; expected quotients come from an
//   integer reference model computed when each request is driven.
module tb_divider_fixed;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct packed {
        logic [15:0] r;
        logic        ovf;
        logic        dbz;
    } exp_t;

    exp_t sbq[$];

    divider_fixed_if bus ();

    divider_fixed dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        longint sa, sd, ma, md, qr;
        bit neg;
        sa  = longint'($signed(a));
        sd  = longint'($signed(b));
        ma  = sa < 0 ? -sa : sa;
        md  = sd < 0 ? -sd : sd;
        neg = (sa < 0) != (sd < 0);
        if (md == 0) return '{sa < 0 ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
        qr = (256 * ma + md) / (2 * md);
        if (!neg) return qr > 32767 ? '{16'h7FFF, 1'b1, 1'b0} : '{16'(qr), 1'b0, 1'b0};
        return qr > 32768 ? '{16'h8000, 1'b1, 1'b0} : '{16'(-qr), 1'b0, 1'b0};
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int glitch);
        int   lat;
        exp_t e;
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        sbq.push_back(model(a, b));
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 16'($urandom);
        check("busy_after_start", bus.busy, 1);
        check("finish_dropped", bus.finish, 0);
        lat = 0;
        while (!bus.finish && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            bus.start = (glitch != 0 && lat == glitch);
        end
        bus.start = 1'b0;
        check("latency", lat, 27);
        check("busy_at_finish", bus.busy, 0);
        e = sbq.pop_front();
        check("result", bus.result, e.r);
        check("overflow_flag", bus.overflow_flag, e.ovf);
        check("div_by_zero", bus.div_by_zero, e.dbz);
    endtask

    initial begin
        bus.dividend = 16'h0000;
        bus.divisor  = 16'h0000;
        bus.start    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", bus.result, 0);
        check("rst_overflow", bus.overflow_flag, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_finish", bus.finish, 0);
        rst = 1'b0;
        do_op(16'h0180, 16'h0100, 0);
        do_op(16'hFE80, 16'h0100, 0);
        do_op(16'h0080, 16'h0180, 0);
        do_op(16'hFF80, 16'h0180, 0);
        do_op(16'h8000, 16'h0080, 0);
        do_op(16'h8000, 16'hFF80, 0);
        do_op(16'h3200, 16'h0001, 0);
        do_op(16'hFF00, 16'h0000, 0);
        do_op(16'h0000, 16'h0000, 0);
        do_op(16'h0000, 16'hFF00, 0);
        do_op(16'h0300, 16'h0080, 8);
        do_op(16'h0100, 16'hFF00, 0);
        for (int i = 0; i < 8; i++) do_op(16'($urandom), 16'($urandom_range(1, 16'hFFFF)), 0);
        @(negedge clk);
        bus.dividend = 16'h0500;
        bus.divisor  = 16'h0300;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("busy_mid_op", bus.busy, 1);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        check("abort_result", bus.result, 0);
        check("abort_overflow", bus.overflow_flag, 0);
        check("abort_dbz", bus.div_by_zero, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_finish", bus.finish, 0);
        @(posedge clk);
        #1;
        check("rst_start_ignored", bus.busy, 0);
        do_op(16'h0280, 16'h0100, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
